// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_pkg
//  Description : Shared types and constants for the 4x4 matrix-keypad
//                scanner: scan state encoding, active-low column drive
//                patterns and key-code width.
//  Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

    // Scanner states, explicitly encoded in two bits
    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    // Active-low one-hot column drive, shared with the display scan side
    localparam logic [3:0] c_COL_PAT0 = 4'b0111;
    localparam logic [3:0] c_COL_PAT1 = 4'b1011;
    localparam logic [3:0] c_COL_PAT2 = 4'b1101;
    localparam logic [3:0] c_COL_PAT3 = 4'b1110;

    // Key code is {row[1:0], col[1:0]}
    localparam int c_KEY_W = 4;

    // Map a column index to its drive pattern
    function automatic logic [3:0] col_pattern(input logic [1:0] idx);
        logic [3:0] pat;
        case (idx)
            2'd0:    pat = c_COL_PAT0;
            2'd1:    pat = c_COL_PAT1;
            2'd2:    pat = c_COL_PAT2;
            default: pat = c_COL_PAT3;
        endcase
        return pat;
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_tick.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_tick
//  Description : Column dwell timer. Counts 0..DWELL_CYCLES-1 and raises a
//                one-cycle sample pulse on the final count of each dwell.
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_tick #(
    parameter int DWELL_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic sample_o
);

    localparam int c_CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(DWELL_CYCLES - 1);

    logic [c_CNT_W-1:0] cnt_q;
    logic [c_CNT_W-1:0] cnt_d;

    // Next count: wrap to zero after the last dwell cycle
    always_comb begin
        cnt_d = (cnt_q == c_LAST) ? '0 : cnt_q + 1'b1;
    end

    // Dwell counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sample_o = (cnt_q == c_LAST);

endmodule
`default_nettype wire

// File: rtl/keypad_scan.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_scan
//  Description : 4x4 matrix-keypad scanner. Drives one column low at a time,
//                samples synchronized rows once per dwell, debounces the
//                first key found and reports its code with a valid strobe.
//                Build option KEYPAD_DEBOUNCE_EN: when defined, DEBOUNCE_CNT
//                matching samples are required to accept a press/release;
//                when undefined the threshold is forced to 1.
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int DWELL_CYCLES = 50000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         row_in,
    output logic [3:0]         col_out,
    output logic [c_KEY_W-1:0] key_code,
    output logic               key_valid,
    output logic               key_down
);

`ifdef KEYPAD_DEBOUNCE_EN
    localparam int c_THRESH = DEBOUNCE_CNT;
`else
    localparam int c_THRESH = 1;
`endif
    localparam int c_CNT_W = (c_THRESH > 1) ? $clog2(c_THRESH + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_THRESH_V = c_CNT_W'(c_THRESH);
    localparam logic [c_CNT_W-1:0] c_ONE      = c_CNT_W'(1);

    logic [3:0]         row_s1_q, row_s2_q;
    state_t             state_q, state_d;
    logic [c_CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [1:0]         col_q, col_d;
    logic [1:0]         cand_q, cand_d;
    logic [c_KEY_W-1:0] key_code_q, key_code_d;
    logic               key_valid_q, key_valid_d;
    logic               key_down_q, key_down_d;
    logic               sample;
    logic               row_active;
    logic [1:0]         win_row;

    keypad_tick #(
        .DWELL_CYCLES(DWELL_CYCLES)
    ) u_tick (
        .clk      (clk),
        .rst      (rst),
        .sample_o (sample)
    );

    // Two-flop synchronizer for the asynchronous row lines (idle = high)
    always_ff @(posedge clk) begin
        if (rst) begin
            row_s1_q <= 4'hF;
            row_s2_q <= 4'hF;
        end else begin
            row_s1_q <= row_in;
            row_s2_q <= row_s1_q;
        end
    end

    // Lowest-index low row wins; value is don't-care when no row is active
    always_comb begin
        row_active = (row_s2_q != 4'hF);
        if (!row_s2_q[0]) begin
            win_row = 2'd0;
        end else if (!row_s2_q[1]) begin
            win_row = 2'd1;
        end else if (!row_s2_q[2]) begin
            win_row = 2'd2;
        end else begin
            win_row = 2'd3;
        end
    end

    // Next-state and output logic; decisions happen only at sample points
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        col_d       = col_q;
        cand_d      = cand_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_down_d  = key_down_q;
        cnt_inc     = cnt_q + 1'b1;

        if (sample) begin
            case (state_q)
                SCAN: begin
                    if (row_active) begin
                        if (c_THRESH == 1) begin
                            key_code_d  = {win_row, col_q};
                            key_valid_d = 1'b1;
                            key_down_d  = 1'b1;
                            cnt_d       = '0;
                            state_d     = PRESSED;
                        end else begin
                            cand_d  = win_row;
                            cnt_d   = c_ONE;
                            state_d = DEBOUNCE;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (row_active && (win_row == cand_q)) begin
                        if (cnt_inc == c_THRESH_V) begin
                            key_code_d  = {cand_q, col_q};
                            key_valid_d = 1'b1;
                            key_down_d  = 1'b1;
                            cnt_d       = '0;
                            state_d     = PRESSED;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        cnt_d   = '0;
                        col_d   = col_q + 1'b1;
                        state_d = SCAN;
                    end
                end
                PRESSED: begin
                    // Active samples, even from another row, keep the key held
                    if (!row_active) begin
                        if (c_THRESH == 1) begin
                            key_down_d = 1'b0;
                            cnt_d      = '0;
                            col_d      = col_q + 1'b1;
                            state_d    = SCAN;
                        end else begin
                            cnt_d   = c_ONE;
                            state_d = RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    if (!row_active) begin
                        if (cnt_inc == c_THRESH_V) begin
                            key_down_d = 1'b0;
                            cnt_d      = '0;
                            col_d      = col_q + 1'b1;
                            state_d    = SCAN;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = PRESSED;
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = SCAN;
                end
            endcase
        end
    end

    // State, column and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SCAN;
            cnt_q       <= '0;
            col_q       <= 2'd0;
            cand_q      <= 2'd0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            col_q       <= col_d;
            cand_q      <= cand_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_down_q  <= key_down_d;
        end
    end

    assign col_out   = col_pattern(col_q);
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_down  = key_down_q;

endmodule
`default_nettype wire
